// File: rtl/rdi_dla_adapter_gen2_if.sv
// DLA and RDI flit/handshake bundle for rdi_dla_adapter_gen2.
// master = adapter side, slave = DLA/RDI environment side.
interface rdi_dla_adapter_gen2_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] dla_data_in;
    logic              dla_valid_in;
    logic              dla_on_off_out;
    logic [DATA_W-1:0] dla_data_out;
    logic              dla_valid_out;
    logic              dla_on_off_in;
    logic [DATA_W-1:0] lp_data;
    logic              lp_valid;
    logic              lp_irdy;
    logic              pl_trdy;
    logic [DATA_W-1:0] pl_data;
    logic              pl_valid;
    logic              pl_crd_rtn;
    logic              lp_crd_rtn;

    modport master (
        input  dla_data_in, dla_valid_in, dla_on_off_in,
        input  pl_trdy, pl_data, pl_valid, pl_crd_rtn,
        output dla_on_off_out, dla_data_out, dla_valid_out,
        output lp_data, lp_valid, lp_irdy, lp_crd_rtn
    );

    modport slave (
        output dla_data_in, dla_valid_in, dla_on_off_in,
        output pl_trdy, pl_data, pl_valid, pl_crd_rtn,
        input  dla_on_off_out, dla_data_out, dla_valid_out,
        input  lp_data, lp_valid, lp_irdy, lp_crd_rtn
    );
endinterface

// File: rtl/rdi_dla_adapter_gen2.sv
// DLA<->RDI adapter: credit-controlled TX FIFO, RX FIFO with credit return, IDLE/ACTIVE/DRAIN sequencing.
// Define ADAPTER_PERF_CNT_EN to add the tx/rx flit counter outputs.
module rdi_dla_adapter_gen2 #(
    parameter  int DATA_W   = 64,
    parameter  int TX_DEPTH = 8,
    parameter  int RX_DEPTH = 8,
    parameter  int CRD_INIT = 8,
    localparam int CRD_W    = $clog2(CRD_INIT + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   enable,
    rdi_dla_adapter_gen2_if.master bus,
    output logic [1:0]             state_o,
    output logic [CRD_W-1:0]       tx_credits_o,
    output logic                   crd_err_o,
    output logic                   rx_ovf_o
`ifdef ADAPTER_PERF_CNT_EN
    ,
    output logic [31:0]            tx_flit_cnt_o,
    output logic [31:0]            rx_flit_cnt_o
`endif
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // TX FIFO
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW:0]    tx_wr_q, tx_rd_q;
    logic              tx_empty, tx_full, tx_push;

    // TX launch register and credits
    logic [DATA_W-1:0] lp_data_q;
    logic              lp_valid_q;
    logic [CRD_W-1:0]  credits_q;
    logic              crd_err_q;
    logic              launch;

    // RX FIFO
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW:0]    rx_wr_q, rx_rd_q;
    logic              rx_empty, rx_full, rx_push, rx_pop;
    logic              rx_ovf_q, lp_crd_rtn_q;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

    // ------------------------------------------------------------------
    // Enable sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)                       state_d = ST_ACTIVE;
                else if (tx_empty && !lp_valid_q) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // TX path: DLA -> FIFO -> launch register -> RDI
    // ------------------------------------------------------------------
    assign bus.dla_on_off_out = (state_q == ST_ACTIVE) && !tx_full;
    assign tx_push = bus.dla_valid_in && bus.dla_on_off_out;
    assign launch  = !tx_empty && (credits_q != '0) &&
                     (!lp_valid_q || bus.pl_trdy) && (state_q != ST_IDLE);

    // NOTE: storage arrays carry no reset; occupancy is governed solely by the reset pointers.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= bus.dla_data_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + (TX_AW+1)'(1);
            if (launch)  tx_rd_q <= tx_rd_q + (TX_AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            lp_data_q  <= '0;
            lp_valid_q <= 1'b0;
        end else if (launch) begin
            lp_data_q  <= tx_mem[tx_rd_q[TX_AW-1:0]];
            lp_valid_q <= 1'b1;
        end else if (bus.pl_trdy) begin
            lp_valid_q <= 1'b0;
        end
    end

    // A return in the launch cycle cancels the spend; a return at full budget is a peer error.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CRD_W'(CRD_INIT);
            crd_err_q <= 1'b0;
        end else begin
            unique case ({launch, bus.pl_crd_rtn})
                2'b10: credits_q <= credits_q - CRD_W'(1);
                2'b01: begin
                    if (credits_q == CRD_W'(CRD_INIT)) crd_err_q <= 1'b1;
                    else                               credits_q <= credits_q + CRD_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.lp_data  = lp_data_q;
    assign bus.lp_valid = lp_valid_q;
    assign bus.lp_irdy  = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // RX path: RDI -> FIFO -> DLA, one credit back per drained flit
    // ------------------------------------------------------------------
    assign rx_pop  = !rx_empty && bus.dla_on_off_in;
    assign rx_push = bus.pl_valid && (!rx_full || rx_pop);

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= bus.pl_data;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_ovf_q     <= 1'b0;
            lp_crd_rtn_q <= 1'b0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + (RX_AW+1)'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + (RX_AW+1)'(1);
            if (bus.pl_valid && !rx_push) rx_ovf_q <= 1'b1;
            lp_crd_rtn_q <= rx_pop;
        end
    end

    // Head is masked while empty so the uninitialised array never reaches the port.
    assign bus.dla_valid_out = !rx_empty;
    assign bus.dla_data_out  = rx_empty ? '0 : rx_mem[rx_rd_q[RX_AW-1:0]];
    assign bus.lp_crd_rtn    = lp_crd_rtn_q;

    assign state_o      = state_q;
    assign tx_credits_o = credits_q;
    assign crd_err_o    = crd_err_q;
    assign rx_ovf_o     = rx_ovf_q;

`ifdef ADAPTER_PERF_CNT_EN
    logic [31:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (lp_valid_q && bus.pl_trdy) tx_cnt_q <= tx_cnt_q + 32'd1;
            if (rx_push)                   rx_cnt_q <= rx_cnt_q + 32'd1;
        end
    end

    assign tx_flit_cnt_o = tx_cnt_q;
    assign rx_flit_cnt_o = rx_cnt_q;
`endif

endmodule
